cmd_queue: RTL
==============

# cmd_queue

Command buffer that sits directly upstream of the memory accelerator's 160-bit command port. It accepts RoCC-format command words from the core, drops words whose funct is not a supported memory opcode, and presents the rest in order through a ready/valid interface. This decouples core issue from accelerator busy periods (store/load/wait/done sequences) and absorbs back-to-back commands.

## Interface
Parameters:
- DEPTH, 4, number of 160-bit entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_cmd  input  160  command word; funct = in_cmd[6:0], rd = [24:20], rs1_data = [95:32], rs2_data = [159:96]
- in_cmd_vld  input  1  in_cmd valid
- in_cmd_rdy  output  1  queue can accept in_cmd this cycle
- out_cmd  output  160  head command word to accelerator
- out_cmd_vld  output  1  out_cmd valid
- out_cmd_rdy  input  1  accelerator accepts out_cmd (its cmd_rdy)
- count  output  CW  number of stored entries, 0..DEPTH
- err_cnt  output  8  dropped-command counter, saturating

## Operation
- Legal funct: 7'd0 (store) and 7'd1 (load). Any other value is illegal.
- Push: in_cmd_vld && in_cmd_rdy. Legal word → written at tail, tail increments mod DEPTH. Illegal word → accepted (handshake completes) but not stored; err_cnt increments.
- Pop: out_cmd_vld && out_cmd_rdy. Head increments mod DEPTH.
- in_cmd_rdy = !rst && (count != DEPTH). It does not depend on out_cmd_rdy.
- out_cmd_vld = (count != 0); out_cmd = entry at head. out_cmd is don't-care when out_cmd_vld=0.
- count: +1 on legal push only, −1 on pop only, unchanged on simultaneous legal push and pop, or on illegal push with pop −1.
- err_cnt saturates at 8'd255, no wrap.
- Storage array is not reset. Pointers, count and err_cnt are reset.
- Order preserved exactly. No reordering, no merging of entries.

## Timing
- Reset (rst=1 at edge): head=tail=0, count=0, err_cnt=0. After that edge, out_cmd_vld=0. While rst=1, in_cmd_rdy=0.
- Reset mid-operation: all stored entries are discarded. A push or pop presented in the reset cycle has no effect.
- Latency, without bypass: a word pushed at edge N is visible on out_cmd with out_cmd_vld=1 after edge N. Earliest pop is at edge N+1.
- Full (count=DEPTH): in_cmd_rdy=0 even if out_cmd_rdy=1. A pop at that edge frees a slot, so in_cmd_rdy=1 in the next cycle (no same-cycle pass-through).
- Empty (count=0): out_cmd_vld=0 and a push does not produce output in the same cycle (except with bypass, below).
- Wrap-around: pointers wrap from DEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Illegal funct while full: in_cmd_rdy=0, so the word is neither accepted nor counted.
- out_cmd and out_cmd_vld must be held stable while out_cmd_vld=1 and out_cmd_rdy=0.

## Configuration
- Macro CMD_QUEUE_BYPASS_EN.
- Defined: when count=0, in_cmd_vld=1, the funct is legal and out_cmd_rdy=1, then:
  - in_cmd drives out_cmd combinationally and out_cmd_vld=1 in the same cycle;
  - the word is consumed by both handshakes and is not stored;
  - count stays 0.
  - Illegal words never bypass.
  - If out_cmd_rdy=0, the word is stored normally.
- Undefined: no combinational in→out path; minimum latency is 1 cycle as above.

## Test plan
- Reset then single store: push funct=0, rs1=64'hDEAD_BEEF, rs2=64'h1000 with out_cmd_rdy=1 → out_cmd_vld=1 one cycle later with identical 160 bits; count goes 1 then 0.
- Fill and stall, DEPTH=4, out_cmd_rdy=0: push 4 legal words → count=4, in_cmd_rdy=0. The 5th word is not accepted. Raise out_cmd_rdy → words pop in order 0..3 and in_cmd_rdy returns 1 the cycle after the first pop.
- Illegal filter: push funct=0, 5, 1, 127 → only 2 entries stored (funct 0 then 1), err_cnt=2. Then 300 illegal pushes → err_cnt=255.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2, output order matches input order across pointer wrap.
- Reset mid-operation: with count=3, pulse rst for one cycle → count=0, out_cmd_vld=0, err_cnt=0. The next push is delivered as the first output.
- With CMD_QUEUE_BYPASS_EN: empty queue, legal push with out_cmd_rdy=1 → out_cmd equals in_cmd in the same cycle and count remains 0. Without the macro, the same stimulus gives out_cmd_vld=1 one cycle later.

Source files
------------

// File: rtl/cmd_queue.sv
// cmd_queue: in-order RoCC command buffer that drops non-memory functs (only store/load pass).
// Optional same-cycle empty-queue bypass is enabled by defining CMD_QUEUE_BYPASS_EN.
module cmd_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [159:0]  in_cmd,
  input  logic          in_cmd_vld,
  output logic          in_cmd_rdy,
  output logic [159:0]  out_cmd,
  output logic          out_cmd_vld,
  input  logic          out_cmd_rdy,
  output logic [CW-1:0] count,
  output logic [7:0]    err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [159:0]  mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    err_q, err_d;
  logic          legal, empty, push, store, pop, bypass;

  assign legal      = (in_cmd[6:0] == 7'd0) || (in_cmd[6:0] == 7'd1);
  assign empty      = (count_q == '0);
  assign in_cmd_rdy = !rst && (count_q != FULL);
  assign push       = in_cmd_vld && in_cmd_rdy;

`ifdef CMD_QUEUE_BYPASS_EN
  // A legal word arriving at an empty queue with a ready consumer skips storage entirely.
  assign bypass      = push && legal && empty && out_cmd_rdy;
  assign out_cmd_vld = !empty || bypass;
  assign out_cmd     = bypass ? in_cmd : mem_q[head_q];
`else
  assign bypass      = 1'b0;
  assign out_cmd_vld = !empty;
  assign out_cmd     = mem_q[head_q];
`endif

  assign store = push && legal && !bypass;
  assign pop   = !empty && out_cmd_rdy;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (pop)   head_d = head_q + AW'(1);
    if (store) tail_d = tail_q + AW'(1);
    if (store && !pop)      count_d = count_q + CW'(1);
    else if (!store && pop) count_d = count_q - CW'(1);
    // Dropped words still complete the handshake; the counter saturates instead of wrapping.
    if (push && !legal && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (store) mem_q[tail_q] <= in_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count   = count_q;
  assign err_cnt = err_q;
endmodule
